// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control FSM with memory-ready handshake
module multicycle_control_unit #(
    parameter int                OP_W     = 6,
    parameter int                ALUOP_W  = 2,
    parameter int                CNT_W    = 32,
    parameter int                EN_ADDI  = 1,
    parameter int                EN_JUMP  = 1,
    parameter logic [OP_W-1:0]   OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0]   OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0]   OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0]   OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0]   OP_ADDI  = 6'b001000,
    parameter logic [OP_W-1:0]   OP_J     = 6'b000010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opCode,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               ALUSrcA,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_op_q;
    logic [CNT_W-1:0]  r_retired;
    logic [1:0]        w_aluop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op_q    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opCode;
            end
            if (instr_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        w_aluop    = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                w_next  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                // Decode from the live opcode; op_q only captures it on this edge
                if (opCode == OP_LW || opCode == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (opCode == OP_RTYPE) begin
                    w_next = S_EXEC;
                end else if (opCode == OP_BEQ) begin
                    w_next = S_BRANCH;
                end else if (EN_ADDI != 0 && opCode == OP_ADDI) begin
                    w_next = S_ADDIEX;
                end else if (EN_JUMP != 0 && opCode == OP_J) begin
                    w_next = S_JUMP;
                end else begin
                    w_next     = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                w_aluop = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                w_aluop    = 2'b01;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
        ALUOp      = '0;
        ALUOp[1:0] = w_aluop;
    end

    assign retired = r_retired;
    assign state   = r_state;

endmodule
